// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler: writes the pixel stream into three rotating line buffers and emits 3x3 windows.
// Latency: a window leaves two cycles after its bottom-right pixel is accepted (BRAM read, then window shift).
// Backpressure: win_ready low freezes the window; the P1 stage then holds and s_axis_ready drops.
// Optional: define CONV_WIN_PERF_EN to add the stall_cnt / win_cnt performance counters.
module conv_window_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13,
  parameter int MAX_WIDTH  = 4096
) (
  input  logic                    axi_clk,
  input  logic                    axi_reset_n,
  input  logic                    start,
  input  logic                    clear,
  input  logic [ADDR_WIDTH-1:0]   cfg_width,
  input  logic [ADDR_WIDTH-1:0]   cfg_height,
  input  logic                    s_axis_valid,
  input  logic [DATA_WIDTH-1:0]   s_axis_data,
  input  logic                    s_axis_last,
  output logic                    s_axis_ready,
  output logic [ADDR_WIDTH-1:0]   bram_wr_addr,
  output logic [2:0]              bram_wr_en,
  output logic [DATA_WIDTH-1:0]   bram_din,
  output logic [ADDR_WIDTH-1:0]   bram_rd_addr,
  output logic                    bram_rd_en,
  input  logic [DATA_WIDTH-1:0]   bram_dout0,
  input  logic [DATA_WIDTH-1:0]   bram_dout1,
  input  logic [DATA_WIDTH-1:0]   bram_dout2,
  output logic [9*DATA_WIDTH-1:0] win_data,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic                    busy,
  output logic                    done,
`ifdef CONV_WIN_PERF_EN
  output logic [31:0]             stall_cnt,
  output logic [31:0]             win_cnt,
`endif
  output logic                    err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] MAX_W = ADDR_WIDTH'(MAX_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] TWO   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] THREE = ADDR_WIDTH'(3);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] w_reg, h_reg, row, col;
  logic [1:0]            wr_sel;
  logic                  p1_valid;
  logic [DATA_WIDTH-1:0] p1_pix;
  logic [ADDR_WIDTH-1:0] p1_r, p1_c;
  logic [1:0]            p1_sel;
  logic [DATA_WIDTH-1:0] win [3][3];

  logic                  shift_ok, shift, accept, is_final, cfg_ok, emit, drain_empty;
  logic [DATA_WIDTH-1:0] top_pix, mid_pix;

  // Handshake, buffer port control and the window-column selection.
  always_comb begin
    cfg_ok       = (cfg_width >= THREE) && (cfg_width <= MAX_W) && (cfg_height >= THREE);
    shift_ok     = !win_valid || win_ready;
    shift        = p1_valid && shift_ok;
    s_axis_ready = (state == S_RUN) && (!p1_valid || shift_ok);
    accept       = s_axis_valid && s_axis_ready;
    is_final     = (row == h_reg - ONE) && (col == w_reg - ONE);
    emit         = (p1_r >= TWO) && (p1_c >= TWO);
    drain_empty  = !p1_valid && !win_valid;
    busy         = (state != S_IDLE);
    bram_wr_en   = accept ? (3'b001 << wr_sel) : 3'b000;
    bram_wr_addr = accept ? col : '0;
    bram_din     = accept ? s_axis_data : '0;
    bram_rd_en   = accept;
    bram_rd_addr = accept ? col : '0;
    // The row written in P1's cycle is the newest; the next buffer in rotation holds the oldest.
    case (p1_sel)
      2'd0:    begin top_pix = bram_dout1; mid_pix = bram_dout2; end
      2'd1:    begin top_pix = bram_dout2; mid_pix = bram_dout0; end
      default: begin top_pix = bram_dout0; mid_pix = bram_dout1; end
    endcase
  end

  // Flatten the window registers; element (r,c) with r0 oldest row, c0 leftmost column.
  always_comb begin
    win_data = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win_data[(r*3+c)*DATA_WIDTH +: DATA_WIDTH] = win[r][c];
  end

  // FSM state register.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) state <= S_IDLE;
    else              state <= state_n;
  end

  // FSM next-state: an early or final pixel ends the frame; drain waits for P1 and the window to empty.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start && cfg_ok) state_n = S_RUN;
      S_RUN:   if (accept && (is_final || s_axis_last)) state_n = S_DRAIN;
      S_DRAIN: if (drain_empty) state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
    if (clear) state_n = S_IDLE;
  end

  // Frame config, counters, P1 stage, window shift register and status flags.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      w_reg     <= '0;
      h_reg     <= '0;
      row       <= '0;
      col       <= '0;
      wr_sel    <= 2'd0;
      p1_valid  <= 1'b0;
      p1_pix    <= '0;
      p1_r      <= '0;
      p1_c      <= '0;
      p1_sel    <= 2'd0;
      win_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else if (clear) begin
      row       <= '0;
      col       <= '0;
      wr_sel    <= 2'd0;
      p1_valid  <= 1'b0;
      win_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE && start) begin
        if (cfg_ok) begin
          w_reg  <= cfg_width;
          h_reg  <= cfg_height;
          row    <= '0;
          col    <= '0;
          wr_sel <= 2'd0;
          err    <= 1'b0;
        end else begin
          err  <= 1'b1;
          done <= 1'b1;
        end
      end
      if (state == S_DRAIN && drain_empty) done <= 1'b1;
      if (accept) begin
        p1_valid <= 1'b1;
        p1_pix   <= s_axis_data;
        p1_r     <= row;
        p1_c     <= col;
        p1_sel   <= wr_sel;
        if (s_axis_last != is_final) err <= 1'b1;
        if (col == w_reg - ONE) begin
          col    <= '0;
          row    <= row + ONE;
          wr_sel <= (wr_sel == 2'd2) ? 2'd0 : wr_sel + 2'd1;
        end else begin
          col <= col + ONE;
        end
      end else if (shift) begin
        p1_valid <= 1'b0;
      end
      // Columns are never flushed at a row start; the c >= 2 gate keeps stale columns out of valid windows.
      if (shift) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= top_pix;
        win[1][2] <= mid_pix;
        win[2][2] <= p1_pix;
        win_valid <= emit;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

`ifdef CONV_WIN_PERF_EN
  // Saturating stall and accepted-window counters, restarted by each start seen in IDLE.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      stall_cnt <= '0;
      win_cnt   <= '0;
    end else if (state == S_IDLE && start) begin
      stall_cnt <= '0;
      win_cnt   <= '0;
    end else begin
      if (win_valid && !win_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (win_valid && win_ready && (win_cnt != '1))    win_cnt   <= win_cnt + 32'd1;
    end
  end
`endif

endmodule
